mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store engine for the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and a multi-cycle data memory that uses a req/ack handshake. It converts a load or store into an aligned word request with byte enables, holds the pipeline stalled until the memory acknowledges, and returns sign- or zero-extended load data to MEM/WB.

Parameters:
- DATA_W, 32, data/address width; only 32 is supported.
- TIMEOUT, 15, maximum cycles in BUSY before abort. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- funct3_i  in  3  access size/sign (RV32I encoding).
- addr_i  in  32  effective address (ALU result).
- wdata_i  in  32  store data (rs2).
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- rdata_o  out  32  formatted load result to MEM/WB.
- err_o  out  1  one-cycle pulse on misaligned, unsupported or aborted access.
- mem_req_o  out  1  memory request; held until ack.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address; bits [1:0] are always 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_ack_i  in  1  one-cycle completion strobe.
- mem_rdata_i  in  32  read word; valid when mem_ack_i = 1.

Behaviour:
- Reset values (asynchronous): state IDLE; mem_req_o, mem_we_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; mem_be_o = 0.
- access = MemRead_i | MemWrite_i. If both are high, the store wins and the load is ignored.
- Legal accesses:
  - LB/LBU/SB: any address.
  - LH/LHU/SH: addr_i[0] = 0.
  - LW/SW: addr_i[1:0] = 0.
  - Any other funct3 is unsupported.
- State IDLE:
  - Legal access: stall_o = 1 combinationally in the same cycle. Next edge → BUSY; latch the address word, mem_be_o, mem_wdata_o, funct3 and addr[1:0]; set mem_req_o = 1 and mem_we_o = MemWrite_i.
  - Illegal access: no request, no stall. err_o pulses for 1 cycle (registered). rdata_o is unchanged.
- State BUSY:
  - mem_req_o = 1 and stall_o = 1. All request outputs stay stable.
  - On mem_ack_i (an ack in the first BUSY cycle is allowed): next edge → DONE and mem_req_o = 0. For loads, rdata_o captures the formatted mem_rdata_i.
- State DONE:
  - stall_o = 0 for exactly 1 cycle so the pipeline advances.
  - Next edge → IDLE unconditionally. The still-present access inputs are never re-issued.
- mem_ack_i outside BUSY is ignored.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0]; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111.
- Load formatting: select the byte or halfword at the latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rdata_o holds its value until the next load completes; stores do not change it.
- Minimum legal access latency: 2 stalled cycles (IDLE detect + 1 BUSY) plus the DONE cycle.
- Reset asserted mid-operation: mem_req_o drops immediately (asynchronously); no ack is expected afterwards.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 4-bit counter cleared on entry to BUSY, incremented each BUSY cycle without ack.
  - When the count reaches TIMEOUT: drop mem_req_o, go to DONE, rdata_o = 0, err_o pulses.
  - If ack and timeout occur in the same cycle, ack wins.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - state typedef {IDLE, BUSY, DONE}.
  - TIMEOUT default.
- Sub-module load_formatter: combinational lane select and extension (funct3, addr[1:0], word → 32-bit result). Reused by any future cache.

Test Plan:
- LW addr = 0x10, ack after 3 cycles with 0xDEADBEEF → stall_o high for 4 cycles, then low; mem_addr_o = 0x10, be = 4'hF, rdata_o = 0xDEADBEEF.
- LB addr = 0x13, mem_rdata_i = 0x80FF_1234 → rdata_o = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr = 0x22, wdata_i = 0x0000ABCD, immediate ack → mem_we_o = 1, be = 4'b1100, mem_wdata_o = 0xABCDABCD, rdata_o unchanged.
- LW addr = 0x06 → no mem_req_o, stall_o = 0, err_o = 1 for one cycle.
- Assert rst_i low while BUSY → mem_req_o = 0 and stall_o = 0 immediately; after release, a new LW completes normally.
- With MEM_TIMEOUT_EN and no ack → abort after 15 BUSY cycles; err_o pulses, rdata_o = 0, state returns to IDLE via DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage load/store engine.
// Holds funct3 encodings, the FSM state type, the timeout default and a legality helper.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Stores only exist as SB/SH/SW; unsigned variants are loads only.
    function automatic logic accessLegal(
        input logic [2:0] f3,
        input logic [1:0] off,
        input logic       isStore
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~isStore;
            F3_HU:   ok = ~isStore & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory bus.
// master drives req/we/addr/be/wdata; slave returns ack and rdata.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [MEM_DATA_W-1:0] mem_addr_o;
    logic [3:0]            mem_be_o;
    logic [MEM_DATA_W-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [MEM_DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: picks the byte/halfword lane of a read word and extends it.
// Ports: funct3 (size/sign), off (addr[1:0]), word (memory word) -> result.
module load_formatter
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = word[8*off +: 8];
    assign halfSel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{24{byteSel[7]}}, byteSel};
            F3_BU:   result = {24'b0, byteSel};
            F3_H:    result = {{16{halfSel[15]}}, halfSel};
            F3_HU:   result = {16'b0, halfSel};
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack data memory.
// Ports: clk_i, rst_i (async low), EX/MEM access inputs, stall_o/rdata_o/err_o, bus (master).
// Optional MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles without ack.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    mem_access_unit_if.master bus
);

    if (DATA_W != 32) begin : gBadWidth
        $error("mem_access_unit supports DATA_W = 32 only");
    end
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : gBadTimeout
        $error("TIMEOUT must fit the 4-bit counter (1..15)");
    end

    state_t      state, nextState;
    logic        access, legal;
    logic        stallRaw, start, bad, ackHit, tmo;
    logic [3:0]  beNext;
    logic [31:0] wdNext;
    logic [2:0]  f3Q;
    logic [1:0]  offQ;
    logic        isLoadQ;
    logic [31:0] fmtData;

    assign access = MemRead_i | MemWrite_i;
    assign legal  = accessLegal(funct3_i, addr_i[1:0], MemWrite_i);

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);
    logic [3:0] tmoCnt;
`endif

    always_comb begin
        nextState = state;
        stallRaw  = 1'b0;
        start     = 1'b0;
        bad       = 1'b0;
        ackHit    = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        start     = 1'b1;
                        stallRaw  = 1'b1;
                        nextState = BUSY;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
                if (bus.mem_ack_i) begin
                    ackHit    = 1'b1;
                    nextState = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmoCnt == TmoLast) begin
                    tmo       = 1'b1;
                    nextState = DONE;
                end
`endif
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Gate with reset so a held access cannot stall the pipe during reset.
    assign stall_o = stallRaw & rst_i;

    always_comb begin
        beNext = 4'b1111;
        wdNext = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                beNext = 4'b0001 << addr_i[1:0];
                wdNext = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                beNext = 4'b0011 << addr_i[1:0];
                wdNext = {2{wdata_i[15:0]}};
            end
            default: begin
                beNext = 4'b1111;
                wdNext = wdata_i;
            end
        endcase
    end

    load_formatter uFmt (
        .funct3 (f3Q),
        .off    (offQ),
        .word   (bus.mem_rdata_i),
        .result (fmtData)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_be_o    <= '0;
            bus.mem_wdata_o <= '0;
            rdata_o         <= '0;
            err_o           <= 1'b0;
            f3Q             <= '0;
            offQ            <= '0;
            isLoadQ         <= 1'b0;
        end else begin
            state <= nextState;
            err_o <= bad | tmo;
            if (start) begin
                bus.mem_req_o   <= 1'b1;
                bus.mem_we_o    <= MemWrite_i;
                bus.mem_addr_o  <= {addr_i[31:2], 2'b00};
                bus.mem_be_o    <= beNext;
                bus.mem_wdata_o <= wdNext;
                f3Q             <= funct3_i;
                offQ            <= addr_i[1:0];
                isLoadQ         <= ~MemWrite_i;
            end
            if (ackHit) begin
                bus.mem_req_o <= 1'b0;
                if (isLoadQ) rdata_o <= fmtData;
            end
            if (tmo) begin
                bus.mem_req_o <= 1'b0;
                rdata_o       <= '0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmoCnt <= '0;
        end else if (start) begin
            tmoCnt <= '0;
        end else if (state == BUSY && !bus.mem_ack_i) begin
            tmoCnt <= tmoCnt + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// A scripted memory model acks in a chosen BUSY cycle with a chosen word.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        err;

    int nCompared = 0;
    int nMismatched = 0;

    int          raStall, raBusy;
    logic [31:0] raAddr, raWd;
    logic [3:0]  raBe;
    logic        raWe, raErr, raDone;

    mem_access_unit_if busIf ();

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clk_i      (clk),
        .rst_i      (rstN),
        .MemRead_i  (memRead),
        .MemWrite_i (memWrite),
        .funct3_i   (funct3),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .rdata_o    (rdata),
        .err_o      (err),
        .bus        (busIf)
    );

    // Presents one access, acks in BUSY cycle ackCycle (0 = never), and
    // returns once stall drops (or after a 40-cycle bound).
    task automatic runAccess(
        input logic        rd,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          ackCycle,
        input logic [31:0] word
    );
        bit done;
        done = 0;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; wdata = wd;
        busIf.mem_ack_i = 1'b0;
        raStall = 0; raBusy = 0; raErr = 1'b0; raWe = 1'b0;
        raAddr = '0; raWd = '0; raBe = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busIf.mem_req_o) begin
                raBusy++;
                raAddr = busIf.mem_addr_o;
                raBe   = busIf.mem_be_o;
                raWd   = busIf.mem_wdata_o;
                raWe   = busIf.mem_we_o;
                if (raBusy == ackCycle) begin
                    busIf.mem_ack_i   = 1'b1;
                    busIf.mem_rdata_i = word;
                end
            end
            if (err) raErr = 1'b1;
            if (stall) raStall++;
            else done = 1;
            @(posedge clk); #1;
            busIf.mem_ack_i = 1'b0;
        end
        raDone = done;
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic test_reset();
        busIf.mem_ack_i = 1'b0;
        busIf.mem_rdata_i = '0;
        @(negedge clk);
        nCompared++;
        if (busIf.mem_req_o !== 1'b0 || busIf.mem_we_o !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_ctrl: req=%b we=%b err=%b stall=%b want 0", busIf.mem_req_o, busIf.mem_we_o, err, stall);
        end
        nCompared++;
        if (busIf.mem_addr_o !== 32'h0 || busIf.mem_be_o !== 4'h0 || busIf.mem_wdata_o !== 32'h0 || rdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset_data: addr=%h be=%h wd=%h rdata=%h want 0", busIf.mem_addr_o, busIf.mem_be_o, busIf.mem_wdata_o, rdata);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_lw();
        runAccess(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 3, 32'hDEADBEEF);
        nCompared++;
        if (raStall !== 4 || raBusy !== 3 || raDone !== 1'b1) begin
            nMismatched++;
            $display("FAIL lw_timing: stall=%0d busy=%0d done=%b want 4 3 1", raStall, raBusy, raDone);
        end
        nCompared++;
        if (raAddr !== 32'h10 || raBe !== 4'hF || raWe !== 1'b0) begin
            nMismatched++;
            $display("FAIL lw_req: addr=%h be=%h we=%b want 10 f 0", raAddr, raBe, raWe);
        end
        @(negedge clk);
        nCompared++;
        if (rdata !== 32'hDEADBEEF || stall !== 1'b0 || busIf.mem_req_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL lw_data: rdata=%h stall=%b req=%b want deadbeef 0 0", rdata, stall, busIf.mem_req_o);
        end
    endtask

    task automatic test_sub_word_load();
        runAccess(1'b1, 1'b0, F3_B, 32'h13, 32'h0, 1, 32'h80FF1234);
        nCompared++;
        if (raStall !== 2 || raAddr !== 32'h10 || raBe !== 4'b1000) begin
            nMismatched++;
            $display("FAIL lb_req: stall=%0d addr=%h be=%b want 2 10 1000", raStall, raAddr, raBe);
        end
        nCompared++;
        if (rdata !== 32'hFFFFFF80) begin
            nMismatched++;
            $display("FAIL lb_data: got %h want ffffff80", rdata);
        end
        runAccess(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 1, 32'h80FF1234);
        nCompared++;
        if (rdata !== 32'h00000080) begin
            nMismatched++;
            $display("FAIL lbu_data: got %h want 00000080", rdata);
        end
        runAccess(1'b1, 1'b0, F3_H, 32'h12, 32'h0, 2, 32'h80FF1234);
        nCompared++;
        if (rdata !== 32'hFFFF80FF || raBe !== 4'b1100 || raStall !== 3) begin
            nMismatched++;
            $display("FAIL lh_data: rdata=%h be=%b stall=%0d want ffff80ff 1100 3", rdata, raBe, raStall);
        end
        runAccess(1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 1, 32'h80FF1234);
        nCompared++;
        if (rdata !== 32'h000080FF) begin
            nMismatched++;
            $display("FAIL lhu_data: got %h want 000080ff", rdata);
        end
    endtask

    task automatic test_store();
        runAccess(1'b0, 1'b1, F3_H, 32'h22, 32'h0000ABCD, 1, 32'h55555555);
        nCompared++;
        if (raWe !== 1'b1 || raBe !== 4'b1100 || raWd !== 32'hABCDABCD || raAddr !== 32'h20) begin
            nMismatched++;
            $display("FAIL sh_req: we=%b be=%b wd=%h addr=%h want 1 1100 abcdabcd 20", raWe, raBe, raWd, raAddr);
        end
        nCompared++;
        if (rdata !== 32'h000080FF || raStall !== 2) begin
            nMismatched++;
            $display("FAIL sh_keep: rdata=%h stall=%0d want 000080ff 2", rdata, raStall);
        end
        runAccess(1'b1, 1'b1, F3_B, 32'h01, 32'h1234565A, 1, 32'h77777777);
        nCompared++;
        if (raWe !== 1'b1 || raBe !== 4'b0010 || raWd !== 32'h5A5A5A5A || raAddr !== 32'h0) begin
            nMismatched++;
            $display("FAIL sb_req: we=%b be=%b wd=%h addr=%h want 1 0010 5a5a5a5a 0", raWe, raBe, raWd, raAddr);
        end
        nCompared++;
        if (rdata !== 32'h000080FF) begin
            nMismatched++;
            $display("FAIL sb_keep: got %h want 000080ff", rdata);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  f3s [3] = '{F3_W, 3'b011, F3_H};
        logic [31:0] as  [3] = '{32'h06, 32'h00, 32'h21};
        logic        ws  [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            runAccess(~ws[k], ws[k], f3s[k], as[k], 32'h0, 1, 32'h0);
            nCompared++;
            if (raStall !== 0 || raBusy !== 0) begin
                nMismatched++;
                $display("FAIL illegal%0d_nostall: stall=%0d busy=%0d want 0 0", k, raStall, raBusy);
            end
            @(negedge clk);
            nCompared++;
            if (err !== 1'b1 || busIf.mem_req_o !== 1'b0 || rdata !== 32'h000080FF) begin
                nMismatched++;
                $display("FAIL illegal%0d_err: err=%b req=%b rdata=%h want 1 0 000080ff", k, err, busIf.mem_req_o, rdata);
            end
            @(negedge clk);
            nCompared++;
            if (err !== 1'b0) begin
                nMismatched++;
                $display("FAIL illegal%0d_pulse: err=%b want 0", k, err);
            end
        end
    endtask

    task automatic test_ack_idle();
        @(posedge clk); #1;
        busIf.mem_ack_i = 1'b1;
        busIf.mem_rdata_i = 32'h11111111;
        @(posedge clk); #1;
        busIf.mem_ack_i = 1'b0;
        @(negedge clk);
        nCompared++;
        if (busIf.mem_req_o !== 1'b0 || stall !== 1'b0 || rdata !== 32'h000080FF) begin
            nMismatched++;
            $display("FAIL ack_idle: req=%b stall=%b rdata=%h want 0 0 000080ff", busIf.mem_req_o, stall, rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        memRead = 1'b1; funct3 = F3_W; addr = 32'h40;
        for (int i = 0; i < 5 && !busIf.mem_req_o; i++) @(negedge clk);
        nCompared++;
        if (busIf.mem_req_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL rstmid_busy: req=%b want 1", busIf.mem_req_o);
        end
        rstN = 1'b0;
        #1;
        nCompared++;
        if (busIf.mem_req_o !== 1'b0 || stall !== 1'b0) begin
            nMismatched++;
            $display("FAIL rstmid_drop: req=%b stall=%b want 0 0", busIf.mem_req_o, stall);
        end
        memRead = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        runAccess(1'b1, 1'b0, F3_W, 32'h44, 32'h0, 2, 32'hCAFEF00D);
        nCompared++;
        if (raStall !== 3 || raAddr !== 32'h44 || rdata !== 32'hCAFEF00D) begin
            nMismatched++;
            $display("FAIL rstmid_after: stall=%0d addr=%h rdata=%h want 3 44 cafef00d", raStall, raAddr, rdata);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        runAccess(1'b1, 1'b0, F3_W, 32'h50, 32'h0, 0, 32'h0);
        nCompared++;
        if (raDone !== 1'b1 || raBusy !== 15 || raStall !== 16 || raErr !== 1'b1) begin
            nMismatched++;
            $display("FAIL timeout_abort: done=%b busy=%0d stall=%0d err=%b want 1 15 16 1", raDone, raBusy, raStall, raErr);
        end
        @(negedge clk);
        nCompared++;
        if (rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0 || busIf.mem_req_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL timeout_after: rdata=%h err=%b stall=%b req=%b want 0 0 0 0", rdata, err, stall, busIf.mem_req_o);
        end
    endtask
`else
    task automatic test_timeout();
        runAccess(1'b1, 1'b0, F3_W, 32'h50, 32'h0, 20, 32'h0BADF00D);
        nCompared++;
        if (raDone !== 1'b1 || raBusy !== 20 || raStall !== 21 || raErr !== 1'b0) begin
            nMismatched++;
            $display("FAIL no_timeout: done=%b busy=%0d stall=%0d err=%b want 1 20 21 0", raDone, raBusy, raStall, raErr);
        end
        nCompared++;
        if (rdata !== 32'h0BADF00D) begin
            nMismatched++;
            $display("FAIL no_timeout_data: got %h want 0badf00d", rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_sub_word_load();
        test_store();
        test_illegal();
        test_ack_idle();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
